// File: rtl/reduction_add_stage.sv
// reduction_add_stage
//   Accumulates a group of beats from the upstream select mux into one result.
//   Each beat is reduced to a single value (add / pass left / pass right /
//   pass left with right forwarded to o_bypass). The per-beat values are summed
//   over a group of N beats, where N is taken from i_fold_num on the first beat.
//   The result sits in a single output register with valid/ready handshake.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no group open; the next accepted beat starts a new group
//   ACC   | group open, r_cnt beats (>0) already folded into r_acc
module reduction_add_stage #(
  parameter int W      = 32,
  parameter int FOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [2*W-1:0]    i_data,
  input  logic [1:0]        i_mode,
  input  logic [FOLD_W-1:0] i_fold_num,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [W-1:0]      o_sum,
  output logic [W-1:0]      o_bypass,
  output logic              o_ovf
);

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  localparam logic [1:0] MODE_ADD   = 2'b00;
  localparam logic [1:0] MODE_LEFT  = 2'b01;
  localparam logic [1:0] MODE_RIGHT = 2'b10;
  localparam logic [1:0] MODE_BOTH  = 2'b11;

  localparam logic [FOLD_W-1:0] CNT_ONE = {{(FOLD_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_state_nxt;
  logic [FOLD_W-1:0]   r_cnt;
  logic [FOLD_W-1:0]   w_cnt_nxt;
  logic [FOLD_W-1:0]   r_len;
  logic [FOLD_W-1:0]   w_len_nxt;
  logic [W-1:0]        r_acc;
  logic [W-1:0]        w_acc_nxt;
  logic                r_grp_ovf;
  logic                w_grp_ovf_nxt;

  logic [W-1:0]        w_left;
  logic [W-1:0]        w_right;
  logic                w_accept;
  logic [W-1:0]        w_pair_sum;
  logic                w_pair_ovf;
  logic [W-1:0]        w_beat_val;
  logic                w_beat_ovf;
  logic [W-1:0]        w_acc_sum;
  logic                w_acc_ovf;
  logic [FOLD_W-1:0]   w_first_len;
  logic [FOLD_W-1:0]   w_cnt_inc;

  logic                w_final;
  logic [W-1:0]        w_final_sum;
  logic                w_final_ovf;
  logic [W-1:0]        w_final_byp;

  assign w_left  = i_data[W-1:0];
  assign w_right = i_data[2*W-1:W];

  // The output register can take a new result whenever it is empty or being drained.
  assign o_ready  = !o_valid || i_ready;
  assign w_accept = i_valid && o_ready;

  // Two's-complement overflow: operands share a sign and the result sign differs.
  assign w_pair_sum = w_left + w_right;
  assign w_pair_ovf = (w_left[W-1] == w_right[W-1]) && (w_pair_sum[W-1] != w_left[W-1]);

  assign w_acc_sum  = r_acc + w_beat_val;
  assign w_acc_ovf  = (r_acc[W-1] == w_beat_val[W-1]) && (w_acc_sum[W-1] != r_acc[W-1]);

  // A fold count of zero would never terminate a group, so treat it as one.
  assign w_first_len = (i_fold_num == '0) ? CNT_ONE : i_fold_num;
  assign w_cnt_inc   = r_cnt + CNT_ONE;

  // Only mode 11 forwards the right operand; the final beat decides o_bypass.
  assign w_final_byp = (i_mode == MODE_BOTH) ? w_right : '0;

  // Reduce the operand pair of the current beat to a single value.
  always_comb begin
    w_beat_val = '0;
    w_beat_ovf = 1'b0;
    case (i_mode)
      MODE_ADD: begin
        w_beat_val = w_pair_sum;
        w_beat_ovf = w_pair_ovf;
      end
      MODE_LEFT:  w_beat_val = w_left;
      MODE_RIGHT: w_beat_val = w_right;
      MODE_BOTH:  w_beat_val = w_left;
      default:    w_beat_val = '0;
    endcase
  end

  // Next-state logic: open, extend or close the group on each accepted beat.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_len_nxt     = r_len;
    w_acc_nxt     = r_acc;
    w_grp_ovf_nxt = r_grp_ovf;
    w_final       = 1'b0;
    w_final_sum   = '0;
    w_final_ovf   = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_first_len == CNT_ONE) begin
            w_final       = 1'b1;
            w_final_sum   = w_beat_val;
            w_final_ovf   = w_beat_ovf;
            w_state_nxt   = IDLE;
            w_cnt_nxt     = '0;
            w_len_nxt     = '0;
            w_acc_nxt     = '0;
            w_grp_ovf_nxt = 1'b0;
          end else begin
            w_state_nxt   = ACC;
            w_cnt_nxt     = CNT_ONE;
            w_len_nxt     = w_first_len;
            w_acc_nxt     = w_beat_val;
            w_grp_ovf_nxt = w_beat_ovf;
          end
        end
      end

      ACC: begin
        if (w_accept) begin
          if (w_cnt_inc == r_len) begin
            w_final       = 1'b1;
            w_final_sum   = w_acc_sum;
            w_final_ovf   = r_grp_ovf | w_beat_ovf | w_acc_ovf;
            w_state_nxt   = IDLE;
            w_cnt_nxt     = '0;
            w_len_nxt     = '0;
            w_acc_nxt     = '0;
            w_grp_ovf_nxt = 1'b0;
          end else begin
            w_cnt_nxt     = w_cnt_inc;
            w_acc_nxt     = w_acc_sum;
            w_grp_ovf_nxt = r_grp_ovf | w_beat_ovf | w_acc_ovf;
          end
        end
      end

      default: begin
        w_state_nxt   = IDLE;
        w_cnt_nxt     = '0;
        w_len_nxt     = '0;
        w_acc_nxt     = '0;
        w_grp_ovf_nxt = 1'b0;
      end
    endcase
  end

  // State, beat counter, group length and running accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_len     <= '0;
      r_acc     <= '0;
      r_grp_ovf <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_len     <= w_len_nxt;
      r_acc     <= w_acc_nxt;
      r_grp_ovf <= w_grp_ovf_nxt;
    end
  end

  // Result register: load on group completion, drop valid once drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid  <= 1'b0;
      o_sum    <= '0;
      o_bypass <= '0;
      o_ovf    <= 1'b0;
    end else if (w_final) begin
      o_valid  <= 1'b1;
      o_sum    <= w_final_sum;
      o_bypass <= w_final_byp;
      o_ovf    <= w_final_ovf;
    end else if (i_ready) begin
      o_valid  <= 1'b0;
    end
  end

endmodule
